// File: rtl/vga_timing_pkg.sv
// XGA 1024x768@70Hz raster constants shared by the timing generator and its counters.
package vga_timing_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 144;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1328

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 806

    localparam int H_W = 11;
    localparam int V_W = 10;

    // Compare constants sized to the counter widths.
    localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START  = H_W'(H_ACTIVE + H_FP);            // 1048
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);   // 1184
    localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START  = V_W'(V_ACTIVE + V_FP);            // 771
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);   // 777

    // One delay-line entry: raw sync levels plus the active-video flag.
    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } tim_t;

    // Drive the active sync level inside [lo, hi), the idle level elsewhere.
    function automatic logic sync_level(input logic [H_W-1:0] v,
                                        input logic [H_W-1:0] lo,
                                        input logic [H_W-1:0] hi,
                                        input logic           pol);
        return ((v >= lo) && (v < hi)) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis counter: counts 0..MAX-1 when enabled and flags the wrap.
// An out-of-range value (e.g. after an upset) is pulled back to 0 on the next clock.
module vga_axis_counter #(
    parameter int MAX   = 1328,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign wrap      = en && w_at_last;
    assign cnt       = r_cnt;

    // Next count: hold by default, recover from illegal values, else step/wrap.
    always_comb begin
        w_next = r_cnt;
        if (r_cnt >= LIMIT) begin
            w_next = '0;
        end else if (en) begin
            w_next = w_at_last ? '0 : r_cnt + WIDTH'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

endmodule

// File: rtl/vga_xga_timing.sv
// XGA raster timing: pixel coordinates for the object generators, and sync/blank
// delayed to line up with their registered RGB before driving the VGA pins.
module vga_xga_timing
    import vga_timing_pkg::*;
#(
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DEPTH = 1
) (
    input  logic             clk75MHz,
    input  logic             rst_n,
    output logic [H_W-1:0]   PixX,
    output logic [V_W-1:0]   PixY,
    output logic             FrameTick,
    output logic             LineTick,
    input  logic [11:0]      RgbIn,
    output logic             HSync,
    output logic             VSync,
    output logic [11:0]      VgaRgb
);

    localparam tim_t IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic w_x_wrap;
    logic w_y_wrap;
    tim_t w_raw;
    tim_t w_dly_out;
    tim_t r_dly [PIPE_DEPTH];

    vga_axis_counter #(.MAX(H_TOTAL), .WIDTH(H_W)) u_xcnt (
        .clk   (clk75MHz),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (PixX),
        .wrap  (w_x_wrap)
    );

    vga_axis_counter #(.MAX(V_TOTAL), .WIDTH(V_W)) u_ycnt (
        .clk   (clk75MHz),
        .rst_n (rst_n),
        .en    (w_x_wrap),
        .cnt   (PixY),
        .wrap  (w_y_wrap)
    );

    // The Y wrap only happens on the X wrap at the last row, i.e. end of frame.
    assign LineTick  = w_x_wrap;
    assign FrameTick = w_y_wrap;

    assign w_raw.hs  = sync_level(PixX, HS_START, HS_END, SYNC_POL);
    assign w_raw.vs  = sync_level({1'b0, PixY}, {1'b0, VS_START}, {1'b0, VS_END}, SYNC_POL);
    assign w_raw.von = (PixX < H_ACT_END) && (PixY < V_ACT_END);

    assign w_dly_out = r_dly[PIPE_DEPTH-1];

    // Delay line matching the object generators' RGB latency; clears to idle.
    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_dly[i] <= IDLE;
            end
        end else begin
            r_dly[0] <= w_raw;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Registered pin stage: blank RGB outside the active area.
    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            HSync  <= ~SYNC_POL;
            VSync  <= ~SYNC_POL;
            VgaRgb <= '0;
        end else begin
            HSync  <= w_dly_out.hs;
            VSync  <= w_dly_out.vs;
            VgaRgb <= w_dly_out.von ? RgbIn : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_xga_timing.sv
// Directed bench for vga_xga_timing: one instance at PIPE_DEPTH=1, one at 3.
module tb_vga_xga_timing;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rgb1, rgb3;

    logic [10:0] PixX1, PixX3;
    logic [9:0]  PixY1, PixY3;
    logic        FT1, FT3, LT1, LT3;
    logic        HS1, HS3, VS1, VS3;
    logic [11:0] Vga1, Vga3;

    int checks   = 0;
    int failures = 0;
    int cnt;
    int ft;
    int fx, fy;

    always #5 clk = ~clk;

    vga_xga_timing #(.SYNC_POL(1'b0), .PIPE_DEPTH(1)) dut1 (
        .clk75MHz (clk),   .rst_n    (rst_n),
        .PixX     (PixX1), .PixY     (PixY1),
        .FrameTick(FT1),   .LineTick (LT1),
        .RgbIn    (rgb1),
        .HSync    (HS1),   .VSync    (VS1),
        .VgaRgb   (Vga1)
    );

    vga_xga_timing #(.SYNC_POL(1'b0), .PIPE_DEPTH(3)) dut3 (
        .clk75MHz (clk),   .rst_n    (rst_n),
        .PixX     (PixX3), .PixY     (PixY3),
        .FrameTick(FT3),   .LineTick (LT3),
        .RgbIn    (rgb3),
        .HSync    (HS3),   .VSync    (VS3),
        .VgaRgb   (Vga3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance k clocks, leaving time 1 unit after the last rising edge.
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rgb1  = 12'hFFF;
        rgb3  = 12'h000;

        // Reset held for 5 clocks
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pixx", PixX1, 0);
        chk("rst_pixy", PixY1, 0);
        chk("rst_hsync", HS1, 1);
        chk("rst_vsync", VS1, 1);
        chk("rst_rgb", Vga1, 0);
        chk("rst_linetick", LT1, 0);
        chk("rst_frametick", FT1, 0);
        chk("rst_rgb_d3", Vga3, 0);

        // Release: counters sit at pixel 0 (n=0)
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pixx", PixX1, 0);
        chk("rel_pixy", PixY1, 0);

        tick(2);    // n=2: pins show pixel (0,0)
        chk("first_rgb", Vga1, 12'hFFF);
        chk("first_hsync", HS1, 1);
        chk("first_pixx", PixX1, 2);

        tick(8);    // n=10
        chk("d3_pixx10", PixX3, 10);
        tick(3);    // n=13: RGB for pixel 10 arrives on the depth-3 instance
        chk("d3_rgb_before", Vga3, 12'h000);
        rgb3 = 12'hF00;
        tick(1);    // n=14
        chk("d3_rgb_hit", Vga3, 12'hF00);
        rgb3 = 12'h000;
        tick(1);    // n=15
        chk("d3_rgb_after", Vga3, 12'h000);

        tick(1010); // n=1025: pins show x=1023
        chk("rgb_last_active", Vga1, 12'hFFF);
        tick(1);    // n=1026: pins show x=1024
        chk("rgb_blank", Vga1, 12'h000);

        tick(23);   // n=1049
        chk("hs_before_fall", HS1, 1);
        tick(1);    // n=1050
        chk("hs_fall", HS1, 0);
        chk("hs_d3_before_fall", HS3, 1);
        tick(2);    // n=1052
        chk("hs_d3_fall", HS3, 0);
        tick(133);  // n=1185
        chk("hs_before_rise", HS1, 0);
        tick(1);    // n=1186
        chk("hs_rise", HS1, 1);

        tick(140);  // n=1326
        chk("lt_1326", LT1, 0);
        chk("pixx_1326", PixX1, 1326);
        tick(1);    // n=1327
        chk("lt_1327", LT1, 1);
        chk("pixy_line0", PixY1, 0);
        chk("ft_line0", FT1, 0);
        tick(1);    // n=1328: line wrap
        chk("wrap_pixx", PixX1, 0);
        chk("wrap_pixy", PixY1, 1);
        chk("wrap_lt", LT1, 0);

        // Jump the row counter to 770 (held across an edge with no line wrap)
        @(negedge clk);
        force dut1.u_ycnt.r_cnt = 10'd770;
        tick(1);
        @(negedge clk);
        release dut1.u_ycnt.r_cnt;
        #1;
        chk("jump770_pixx", PixX1, 1);
        chk("jump770_pixy", PixY1, 770);

        cnt = 0;
        for (int i = 0; i < 9 * 1328; i++) begin
            tick(1);
            if (VS1 == 1'b0) cnt++;
        end
        chk("vsync_low_clocks", cnt, 6 * 1328);
        chk("after_vs_pixy", PixY1, 779);
        chk("after_vs_pixx", PixX1, 1);

        // Jump to row 804 and run across the frame wrap
        @(negedge clk);
        force dut1.u_ycnt.r_cnt = 10'd804;
        tick(1);
        @(negedge clk);
        release dut1.u_ycnt.r_cnt;
        #1;
        chk("jump804_pixx", PixX1, 2);
        chk("jump804_pixy", PixY1, 804);

        ft = 0; fx = -1; fy = -1;
        for (int i = 0; i < 2654; i++) begin
            tick(1);
            if (FT1 == 1'b1) begin
                ft++;
                fx = int'(PixX1);
                fy = int'(PixY1);
            end
        end
        chk("frametick_count", ft, 1);
        chk("frametick_x", fx, 1327);
        chk("frametick_y", fy, 805);
        chk("frame_next_x", PixX1, 0);
        chk("frame_next_y", PixY1, 0);

        // Move to (500,300) and reset mid-frame
        @(negedge clk);
        force dut1.u_ycnt.r_cnt = 10'd300;
        tick(1);
        @(negedge clk);
        release dut1.u_ycnt.r_cnt;
        #1;
        tick(499);
        chk("mid_pixx", PixX1, 500);
        chk("mid_pixy", PixY1, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pixx", PixX1, 0);
        chk("async_pixy", PixY1, 0);
        chk("async_pixx_d3", PixX3, 0);
        chk("async_hsync", HS1, 1);
        chk("async_rgb", Vga1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_pixx", PixX1, 0);
        chk("held_vsync", VS1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerel_pixx", PixX1, 0);
        chk("rerel_pixy", PixY1, 0);
        tick(1);
        chk("restart_pixx", PixX1, 1);
        tick(1);
        chk("restart_rgb", Vga1, 12'hFFF);
        chk("restart_hsync", HS1, 1);
        chk("restart_pixx_d3", PixX3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
